// File: rtl/grid_bank_if.sv
// Load and requester bus for grid_bank; width macros default here unless given on the command line.
`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 8
`endif
`ifndef GRID_VEC_ALIGN_N
`define GRID_VEC_ALIGN_N 16
`endif
`ifndef BANK_DEPTH
`define BANK_DEPTH 4
`endif
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 3
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH $clog2(`GRID_VEC_ALIGN_N)
`endif

interface grid_bank_if #(
  parameter int unsigned NUM_PORTS = 2
);
  localparam int unsigned TX_W   = `TX_DATA_WIDTH;
  localparam int unsigned ADDR_W = `BANK_ADDR_WIDTH;
  localparam int unsigned COL_W  = `COL_ADDR_WIDTH;

  logic                        load_valid;
  logic [TX_W-1:0]             load_data;
  logic                        load_ready;
  logic                        load_done_out;
  logic [NUM_PORTS-1:0]        req_read_en;
  logic [NUM_PORTS-1:0]        req_write_en;
  logic [NUM_PORTS*ADDR_W-1:0] req_row_addr;
  logic [NUM_PORTS*COL_W-1:0]  req_col_addr;
  logic [NUM_PORTS*TX_W-1:0]   req_wdata;
  logic [NUM_PORTS-1:0]        ack_out;
  logic [TX_W-1:0]             rdata_out;
  logic                        changed_out;
  logic                        clear_changed;

  modport master (
    output load_valid, load_data, req_read_en, req_write_en,
           req_row_addr, req_col_addr, req_wdata, clear_changed,
    input  load_ready, load_done_out, ack_out, rdata_out, changed_out
  );

  modport slave (
    input  load_valid, load_data, req_read_en, req_write_en,
           req_row_addr, req_col_addr, req_wdata, clear_changed,
    output load_ready, load_done_out, ack_out, rdata_out, changed_out
  );
endinterface

// File: rtl/grid_bank.sv
// Row/chunk storage bank: streamed initial load, then round-robin multi-port chunk read/write.
// Optional sticky write-changed flag enabled by defining BANK_CHANGE_FLAG_EN.
module grid_bank #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DEPTH     = `BANK_DEPTH,
  parameter int unsigned CHUNKS    = `GRID_VEC_ALIGN_N / `TX_DATA_WIDTH
) (
  input  logic        clock,
  input  logic        reset_n,
  grid_bank_if.slave  bus
);
  localparam int unsigned TX_W   = `TX_DATA_WIDTH;
  localparam int unsigned ADDR_W = `BANK_ADDR_WIDTH;
  localparam int unsigned COL_W  = `COL_ADDR_WIDTH;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CHK_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {ST_LOAD, ST_SERVE} state_e;

  state_e                          state_q, state_d;
  logic [PTR_W-1:0]                row_ptr_q, row_ptr_d;
  logic [CHK_W-1:0]                chunk_ptr_q, chunk_ptr_d;
  logic [PORT_W-1:0]               rr_q, rr_d;
  logic [NUM_PORTS-1:0]            ack_q, ack_d;
  logic [TX_W-1:0]                 rdata_q, rdata_d;
  logic                            load_ready_q, load_ready_d;
  logic                            load_done_q, load_done_d;
  logic [CHUNKS-1:0][TX_W-1:0]     mem_q [DEPTH];
  logic [CHUNKS-1:0][TX_W-1:0]     mem_d [DEPTH];

  logic [ADDR_W-1:0]               row_a   [NUM_PORTS];
  logic [COL_W-1:0]                col_a   [NUM_PORTS];
  logic [TX_W-1:0]                 wdata_a [NUM_PORTS];

  logic                            gnt_vld_c;
  logic [PORT_W-1:0]               gnt_idx_c;
  logic [PORT_W-1:0]               idx_c;
  logic                            in_range_c;
  logic [CHK_W-1:0]                chunk_c;
  logic [TX_W-1:0]                 old_c;
  logic                            do_write_c;

  // Unpack the flattened per-port request fields.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign row_a[p]   = bus.req_row_addr[p*ADDR_W +: ADDR_W];
    assign col_a[p]   = bus.req_col_addr[p*COL_W +: COL_W];
    assign wdata_a[p] = bus.req_wdata[p*TX_W +: TX_W];
  end

`ifdef BANK_CHANGE_FLAG_EN
  logic changed_q, changed_d;
`else
  logic unused_clear_changed;
  assign unused_clear_changed = bus.clear_changed;
`endif

  always_comb begin
    state_d     = state_q;
    row_ptr_d   = row_ptr_q;
    chunk_ptr_d = chunk_ptr_q;
    rr_d        = rr_q;
    ack_d       = '0;
    rdata_d     = '0;
    mem_d       = mem_q;
    gnt_vld_c   = 1'b0;
    gnt_idx_c   = '0;
    idx_c       = '0;
    in_range_c  = 1'b0;
    chunk_c     = '0;
    old_c       = '0;
    do_write_c  = 1'b0;
`ifdef BANK_CHANGE_FLAG_EN
    changed_d   = changed_q & ~bus.clear_changed;
`endif

    unique case (state_q)
      ST_LOAD: begin
        if (bus.load_valid) begin
          mem_d[row_ptr_q][chunk_ptr_q] = bus.load_data;
          if (chunk_ptr_q == CHK_W'(CHUNKS - 1)) begin
            chunk_ptr_d = '0;
            row_ptr_d   = row_ptr_q + PTR_W'(1);
            if (row_ptr_q == PTR_W'(DEPTH - 1)) state_d = ST_SERVE;
          end else begin
            chunk_ptr_d = chunk_ptr_q + CHK_W'(1);
          end
        end
      end
      ST_SERVE: begin
        // Scan from the round-robin pointer; a port acked this cycle sits out.
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          idx_c = PORT_W'((32'(rr_q) + i) % NUM_PORTS);
          if (!gnt_vld_c && (bus.req_read_en[idx_c] || bus.req_write_en[idx_c])
              && !ack_q[idx_c]) begin
            gnt_vld_c = 1'b1;
            gnt_idx_c = idx_c;
          end
        end
        if (gnt_vld_c) begin
          in_range_c = (row_a[gnt_idx_c] < ADDR_W'(DEPTH));
          chunk_c    = CHK_W'(col_a[gnt_idx_c] / COL_W'(TX_W));
          old_c      = in_range_c ? mem_q[PTR_W'(row_a[gnt_idx_c])][chunk_c] : '0;
          do_write_c = in_range_c && bus.req_write_en[gnt_idx_c];
          ack_d[gnt_idx_c] = 1'b1;
          rdata_d    = old_c;
          rr_d       = PORT_W'((32'(gnt_idx_c) + 1) % NUM_PORTS);
          if (do_write_c) begin
            mem_d[PTR_W'(row_a[gnt_idx_c])][chunk_c] = wdata_a[gnt_idx_c];
          end
`ifdef BANK_CHANGE_FLAG_EN
          if (do_write_c && (wdata_a[gnt_idx_c] != old_c)) changed_d = 1'b1;
`endif
        end
      end
    endcase

    load_ready_d = (state_d == ST_LOAD);
    load_done_d  = (state_d == ST_SERVE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_LOAD;
      row_ptr_q    <= '0;
      chunk_ptr_q  <= '0;
      rr_q         <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      load_ready_q <= 1'b1;
      load_done_q  <= 1'b0;
`ifdef BANK_CHANGE_FLAG_EN
      changed_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      row_ptr_q    <= row_ptr_d;
      chunk_ptr_q  <= chunk_ptr_d;
      rr_q         <= rr_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
`ifdef BANK_CHANGE_FLAG_EN
      changed_q    <= changed_d;
`endif
    end
  end

  // Storage survives reset; updates are suppressed while reset is asserted.
  always_ff @(posedge clock) begin
    if (reset_n) mem_q <= mem_d;
  end

  assign bus.load_ready    = load_ready_q;
  assign bus.load_done_out = load_done_q;
  assign bus.ack_out       = ack_q;
  assign bus.rdata_out     = rdata_q;
`ifdef BANK_CHANGE_FLAG_EN
  assign bus.changed_out   = changed_q;
`else
  assign bus.changed_out   = 1'b0;
`endif
endmodule

// File: tb/tb_grid_bank.sv
// Self-checking bench for grid_bank (TX=8, 16-bit rows, DEPTH=4, 2 ports).
module tb_grid_bank;
`ifdef BANK_CHANGE_FLAG_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif

  logic clock;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  grid_bank_if #(.NUM_PORTS(2)) bus ();

  grid_bank #(.NUM_PORTS(2), .DEPTH(4), .CHUNKS(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Reference model: bank contents, next-priority port, acks expected this cycle, sticky flag.
  logic [7:0] mem_m [4][2];
  int         prio_m;
  logic [1:0] ack_m;
  bit         chg_m;

  typedef struct {
    int         port;
    bit         rd;
    bit         wr;
    int         row;
    int         col;
    logic [7:0] wd;
    logic [1:0] exp_ack;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_req();
    bus.req_read_en  = '0;
    bus.req_write_en = '0;
    bus.req_row_addr = '0;
    bus.req_col_addr = '0;
    bus.req_wdata    = '0;
  endtask

  task automatic set_req(input int p, input bit rd, input bit wr, input int row,
                         input int col, input logic [7:0] wd);
    bus.req_read_en[p]          = rd;
    bus.req_write_en[p]         = wr;
    bus.req_row_addr[p*3 +: 3]  = 3'(row);
    bus.req_col_addr[p*4 +: 4]  = 4'(col);
    bus.req_wdata[p*8 +: 8]     = wd;
  endtask

  // Predict the serving cycle from the currently driven inputs, clock it, compare.
  task automatic run_cycle(input string tag);
    logic [1:0] e_ack;
    logic [7:0] e_rd;
    logic [7:0] wd;
    bit         set_chg;
    int         gnt;
    int         r;
    int         c;
    e_ack   = '0;
    e_rd    = '0;
    set_chg = 1'b0;
    gnt     = -1;
    for (int k = 0; k < 2; k++) begin
      int p;
      p = (prio_m + k) % 2;
      if (gnt < 0 && (bus.req_read_en[p] || bus.req_write_en[p]) && !ack_m[p]) gnt = p;
    end
    if (gnt >= 0) begin
      r  = int'(bus.req_row_addr[gnt*3 +: 3]);
      c  = int'(bus.req_col_addr[gnt*4 +: 4]) / 8;
      wd = bus.req_wdata[gnt*8 +: 8];
      e_ack[gnt] = 1'b1;
      if (r < 4) e_rd = mem_m[r][c];
      if (bus.req_write_en[gnt] && r < 4) begin
        if (mem_m[r][c] != wd) set_chg = 1'b1;
        mem_m[r][c] = wd;
      end
      prio_m = (gnt + 1) % 2;
    end
    if (bus.clear_changed) chg_m = 1'b0;
    if (set_chg) chg_m = 1'b1;
    ack_m = e_ack;
    tick();
    check({tag, " ack"}, 32'(bus.ack_out), 32'(e_ack));
    check({tag, " rdata"}, 32'(bus.rdata_out), 32'(e_rd));
    check({tag, " changed"}, 32'(bus.changed_out), 32'(CHG_EN & chg_m));
  endtask

  // Stream mem_m into the bank with gaps while requests are held (they must be ignored).
  task automatic do_load();
    for (int b = 0; b < 8; b++) begin
      int gaps;
      bus.load_valid   = 1'b1;
      bus.load_data    = mem_m[b/2][b%2];
      bus.req_read_en  = 2'b11;
      bus.req_write_en = 2'b01;
      bus.req_wdata    = 16'hEEEE;
      tick();
      check("load ack", 32'(bus.ack_out), 32'd0);
      if (b < 7) begin
        check("load done early", 32'(bus.load_done_out), 32'd0);
        check("load ready", 32'(bus.load_ready), 32'd1);
      end else begin
        check("load done", 32'(bus.load_done_out), 32'd1);
        check("load ready serve", 32'(bus.load_ready), 32'd0);
      end
      bus.load_valid = 1'b0;
      gaps = (b == 7) ? 0 : ((b % 2 == 0) ? 1 : int'($urandom_range(0, 2)));
      for (int g = 0; g < gaps; g++) begin
        tick();
        check("gap ack", 32'(bus.ack_out), 32'd0);
        check("gap done", 32'(bus.load_done_out), 32'd0);
      end
    end
    clear_req();
    ack_m = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 1'b1, 1'b0, 2,  8, 8'h00, 2'b01, 8'h15};
    vecs[1] = '{1, 1'b1, 1'b0, 0,  0, 8'h00, 2'b10, 8'h10};
    vecs[2] = '{0, 1'b1, 1'b0, 3, 15, 8'h00, 2'b01, 8'h17};
    vecs[3] = '{1, 1'b1, 1'b0, 7,  0, 8'h00, 2'b10, 8'h00};
    vecs[4] = '{0, 1'b0, 1'b1, 7,  8, 8'h5A, 2'b01, 8'h00};
    vecs[5] = '{1, 1'b1, 1'b0, 3,  8, 8'h00, 2'b10, 8'h17};
    vecs[6] = '{0, 1'b1, 1'b1, 3,  0, 8'h33, 2'b01, 8'h16};
    vecs[7] = '{1, 1'b1, 1'b0, 3,  3, 8'h00, 2'b10, 8'h33};
    vecs[8] = '{0, 1'b1, 1'b0, 0,  9, 8'h00, 2'b01, 8'h11};

    n_tests = 0;
    n_fail  = 0;
    clock   = 1'b0;
    reset_n = 1'b0;
    bus.load_valid    = 1'b0;
    bus.load_data     = '0;
    bus.clear_changed = 1'b0;
    clear_req();
    prio_m = 0;
    ack_m  = '0;
    chg_m  = 1'b0;

    tick();
    tick();
    check("rst ack", 32'(bus.ack_out), 32'd0);
    check("rst rdata", 32'(bus.rdata_out), 32'd0);
    check("rst ready", 32'(bus.load_ready), 32'd1);
    check("rst done", 32'(bus.load_done_out), 32'd0);
    check("rst changed", 32'(bus.changed_out), 32'd0);
    reset_n = 1'b1;

    for (int b = 0; b < 8; b++) mem_m[b/2][b%2] = 8'(8'h10 + b);
    do_load();

    foreach (vecs[i]) begin
      clear_req();
      set_req(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].row, vecs[i].col, vecs[i].wd);
      run_cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl ack", i), 32'(bus.ack_out), 32'(vecs[i].exp_ack));
      check($sformatf("vec%0d tbl rdata", i), 32'(bus.rdata_out), 32'(vecs[i].exp_rd));
      clear_req();
      run_cycle($sformatf("vec%0d idle", i));
    end

    // Write then immediate read-back of the same chunk, with change-flag behaviour.
    bus.clear_changed = 1'b1;
    run_cycle("clr0");
    bus.clear_changed = 1'b0;
    check("clr0 flag", 32'(bus.changed_out), 32'd0);
    set_req(1, 1'b0, 1'b1, 1, 0, 8'hAA);
    run_cycle("wr aa");
    check("wr aa ack", 32'(bus.ack_out), 32'b10);
    check("wr aa old", 32'(bus.rdata_out), 32'h12);
    check("wr aa flag", 32'(bus.changed_out), 32'(CHG_EN));
    clear_req();
    set_req(0, 1'b1, 1'b0, 1, 0, 8'h00);
    run_cycle("rd aa");
    check("rd aa ack", 32'(bus.ack_out), 32'b01);
    check("rd aa data", 32'(bus.rdata_out), 32'hAA);
    clear_req();
    bus.clear_changed = 1'b1;
    run_cycle("clr1");
    bus.clear_changed = 1'b0;
    check("clr1 flag", 32'(bus.changed_out), 32'd0);
    set_req(1, 1'b0, 1'b1, 1, 0, 8'hAA);
    run_cycle("rewr aa");
    check("rewr aa flag", 32'(bus.changed_out), 32'd0);
    check("rewr aa old", 32'(bus.rdata_out), 32'hAA);
    clear_req();
    run_cycle("rewr idle");
    check("rewr idle flag", 32'(bus.changed_out), 32'd0);

    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        set_req(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 15)), 8'($urandom));
      end
      bus.clear_changed = ($urandom_range(0, 15) == 0);
      run_cycle("rnd");
    end
    bus.clear_changed = 1'b0;
    clear_req();

    // Reset with a read pending mid-serve, then reload and interleave both ports.
    set_req(0, 1'b1, 1'b0, 2, 0, 8'h00);
    reset_n = 1'b0;
    tick();
    check("rst2 ack", 32'(bus.ack_out), 32'd0);
    check("rst2 rdata", 32'(bus.rdata_out), 32'd0);
    check("rst2 ready", 32'(bus.load_ready), 32'd1);
    check("rst2 done", 32'(bus.load_done_out), 32'd0);
    check("rst2 changed", 32'(bus.changed_out), 32'd0);
    reset_n = 1'b1;
    clear_req();
    prio_m = 0;
    ack_m  = '0;
    chg_m  = 1'b0;
    do_load();

    for (int k = 0; k < 8; k++) begin
      set_req(0, 1'b1, 1'b0, k % 4, 0, 8'h00);
      set_req(1, 1'b1, 1'b0, k % 4, 8, 8'h00);
      run_cycle($sformatf("rr%0d", k));
      check($sformatf("rr%0d alt", k), 32'(bus.ack_out), (k % 2 == 0) ? 32'b01 : 32'b10);
    end
    clear_req();
    run_cycle("final idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
